// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding, instruction codes and address helper for the MAC array sequencer.
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARST  = 3'd1,
      S_KLOAD = 3'd2,
      S_KGAP  = 3'd3,
      S_EXEC  = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [1:0] INST_IDLE = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

   localparam int INST_BIT_LOAD = 0;
   localparam int INST_BIT_EXEC = 1;

   // Linear weight address before truncation to the read-address width.
   function automatic logic [31:0] lin_addr(input logic [31:0] kij, input logic [31:0] k,
                                            input logic [31:0] stride);
      return kij * stride + k;
   endfunction

endpackage

// File: rtl/inst_skew.sv
// Row-skew shift register: stage r holds the instruction seen by array row r.
module inst_skew
   import mac_ctrl_pkg::*;
#(
   parameter int ROW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        i_inst,
   output logic [2*ROW-1:0]  o_inst_w
);

   logic [ROW-1:0][1:0] r_stage;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_inst;
         for (int r = 1; r < ROW; r++) begin
            r_stage[r] <= r_stage[r-1];
         end
      end
   end

   assign o_inst_w = r_stage;

endmodule

// File: rtl/mac_array_ctrl.sv
// Weight-stationary MAC array sequencer: per kernel reset, load weights, execute, drain.
module mac_array_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int LEN_NIJ = 36,
   parameter int N_KIJ   = 9,
   parameter int ADDR_BW = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               array_rst,
   output logic               w_rd,
   output logic [ADDR_BW-1:0] w_addr,
   output logic               x_rd,
   output logic [ADDR_BW-1:0] x_addr,
   output logic [2*ROW-1:0]   inst_w
);

   localparam int PH_MAX = (ROW + COL > LEN_NIJ) ? ROW + COL : LEN_NIJ;
   localparam int CNT_W  = $clog2(PH_MAX + 1);
   localparam int KIJ_W  = $clog2(N_KIJ + 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [KIJ_W-1:0]   r_kij;
   logic               r_busy;
   logic               r_done;
   logic               r_arst;
   logic               r_w_rd;
   logic [ADDR_BW-1:0] r_w_addr;
   logic               r_x_rd;
   logic [ADDR_BW-1:0] r_x_addr;
   logic [1:0]         w_inst;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_kij    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_arst   <= 1'b0;
         r_w_rd   <= 1'b0;
         r_w_addr <= '0;
         r_x_rd   <= 1'b0;
         r_x_addr <= '0;
      end else begin
         // Strobes and addresses default low; each state re-asserts what the next cycle needs.
         r_done   <= 1'b0;
         r_arst   <= 1'b0;
         r_w_rd   <= 1'b0;
         r_w_addr <= '0;
         r_x_rd   <= 1'b0;
         r_x_addr <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (N_KIJ * COL > (1 << ADDR_BW))
                     $warning("mac_array_ctrl: n_kij*col exceeds address space, w_addr wraps");
                  r_state <= S_ARST;
                  r_kij   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_arst  <= 1'b1;
               end
            end
            S_ARST: begin
               r_state  <= S_KLOAD;
               r_cnt    <= '0;
               r_w_rd   <= 1'b1;
               r_w_addr <= ADDR_BW'(lin_addr(32'(r_kij), 32'd0, 32'(COL)));
            end
            S_KLOAD: begin
               if (r_cnt == CNT_W'(COL - 1)) begin
                  r_state <= S_KGAP;
                  r_cnt   <= '0;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_w_rd   <= 1'b1;
                  r_w_addr <= ADDR_BW'(lin_addr(32'(r_kij), 32'(r_cnt) + 32'd1, 32'(COL)));
               end
            end
            S_KGAP: begin
               r_state  <= S_EXEC;
               r_cnt    <= '0;
               r_x_rd   <= 1'b1;
               r_x_addr <= '0;
            end
            S_EXEC: begin
               if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_x_rd   <= 1'b1;
                  r_x_addr <= ADDR_BW'(32'(r_cnt) + 32'd1);
               end
            end
            S_DRAIN: begin
               if (r_cnt == CNT_W'(ROW + COL - 1)) begin
                  r_cnt <= '0;
                  if (r_kij < KIJ_W'(N_KIJ - 1)) begin
                     r_kij   <= r_kij + 1'b1;
                     r_state <= S_ARST;
                     r_arst  <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Row-0 inst follows the read strobes by one register so it meets the read data.
   always_comb begin
      w_inst                = INST_IDLE;
      w_inst[INST_BIT_LOAD] = r_w_rd;
      w_inst[INST_BIT_EXEC] = r_x_rd;
   end

   inst_skew #(.ROW(ROW)) u_skew (
      .clk      (clk),
      .reset    (reset),
      .i_inst   (w_inst),
      .o_inst_w (inst_w)
   );

   assign busy      = r_busy;
   assign done      = r_done;
   assign array_rst = r_arst;
   assign w_rd      = r_w_rd;
   assign w_addr    = r_w_addr;
   assign x_rd      = r_x_rd;
   assign x_addr    = r_x_addr;

endmodule
